// File: rtl/mem_sweep_scheduler_if.sv
// Request/stall and address-stream bundle between the sweep scheduler and its two requesters.
// The scheduler takes the master side; requesters and the frame-buffer mux take the slave side.
interface mem_sweep_scheduler_if #(
    parameter int ADDR_W = 16
);
    logic [1:0]        req;
    logic              stall;
    logic [1:0]        grant;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic              last;
    logic [1:0]        done;
    logic              busy;

    modport master (
        input  req, stall,
        output grant, mem_addr, mem_valid, last, done, busy
    );

    modport slave (
        output req, stall,
        input  grant, mem_addr, mem_valid, last, done, busy
    );
endinterface

// File: rtl/mem_sweep_scheduler.sv
// Full-frame address sweep scheduler: grants one of two requesters and walks 0..DEPTH-1.
// Define SWEEP_ROUND_ROBIN_EN for round-robin tie-break; otherwise requester 0 has fixed priority.
module mem_sweep_scheduler #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 57600
) (
    input  logic                    clk,
    input  logic                    resetn,
    mem_sweep_scheduler_if.master   bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t            state, state_n;
    logic [1:0]        grant_q, grant_n;
    logic [1:0]        done_q, done_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              valid_q, valid_n;
    logic              busy_q, busy_n;
    logic              last_owner, last_owner_n;
    logic [1:0]        winner;

`ifdef SWEEP_ROUND_ROBIN_EN
    // On a tie the requester that did not own the previous sweep wins.
    always_comb begin
        if (bus.req == 2'b11) winner = last_owner ? 2'b01 : 2'b10;
        else                  winner = bus.req;
    end
`else
    always_comb begin
        winner = bus.req[0] ? 2'b01 : bus.req;
    end

    // last_owner is kept so both builds share the same state; fixed priority never reads it.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        state_n      = state;
        grant_n      = grant_q;
        addr_n       = addr_q;
        valid_n      = valid_q;
        done_n       = 2'b00;
        last_owner_n = last_owner;
        case (state)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    state_n = SWEEP;
                    grant_n = winner;
                    addr_n  = '0;
                    valid_n = 1'b1;
                end
            end
            SWEEP: begin
                if (!bus.stall) begin
                    if (addr_q == LAST_ADDR) begin
                        state_n = DONE;
                        done_n  = grant_q;
                        grant_n = 2'b00;
                        addr_n  = '0;
                        valid_n = 1'b0;
                    end else begin
                        addr_n = addr_q + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                state_n      = IDLE;
                last_owner_n = done_q[1];
            end
            default: begin
                state_n = IDLE;
                grant_n = 2'b00;
                addr_n  = '0;
                valid_n = 1'b0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            grant_q    <= 2'b00;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 2'b00;
            busy_q     <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_n;
            grant_q    <= grant_n;
            addr_q     <= addr_n;
            valid_q    <= valid_n;
            done_q     <= done_n;
            busy_q     <= busy_n;
            last_owner <= last_owner_n;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_valid = valid_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.last      = valid_q && (addr_q == LAST_ADDR);

    // Structural invariants of the registered outputs.
    a_grant_onehot: assert property (@(posedge clk) disable iff (!resetn) $onehot0(grant_q));
    a_done_onehot:  assert property (@(posedge clk) disable iff (!resetn) $onehot0(done_q));
    a_addr_range:   assert property (@(posedge clk) disable iff (!resetn) addr_q <= LAST_ADDR);
    a_valid_grant:  assert property (@(posedge clk) disable iff (!resetn) valid_q == (grant_q != 2'b00));
endmodule

// File: tb/tb_mem_sweep_scheduler.sv
// Scoreboard bench: stimulus pushes cycle-stamped expected output events, monitors pop and compare.
module tb_mem_sweep_scheduler;
    localparam int DA  = 1200;
    localparam int AWA = 16;
    localparam int DB  = 4;
    localparam int AWB = 2;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_sweep_scheduler_if #(.ADDR_W(AWA)) ifa ();
    mem_sweep_scheduler_if #(.ADDR_W(AWB)) ifb ();

    mem_sweep_scheduler #(.ADDR_W(AWA), .DEPTH(DA)) dut_a (.clk(clk), .resetn(resetn), .bus(ifa));
    mem_sweep_scheduler #(.ADDR_W(AWB), .DEPTH(DB)) dut_b (.clk(clk), .resetn(resetn), .bus(ifb));

    typedef struct packed {
        int          cyc;
        logic [1:0]  grant;
        logic [15:0] addr;
        logic        valid;
        logic        last;
        logic        busy;
        logic [1:0]  done;
    } evt_t;

    evt_t qa[$];
    evt_t qb[$];
    int n_chk  = 0;
    int n_pass = 0;

    function automatic string fmt(input evt_t e);
        return $sformatf("cyc=%0d grant=%b addr=%0d valid=%b last=%b busy=%b done=%b",
                         e.cyc, e.grant, e.addr, e.valid, e.last, e.busy, e.done);
    endfunction

    task automatic tally(input bit ok, input string msg);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s", msg);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step(1);
    endtask

    // Expected events for one sweep starting (grant visible) at cycle start; stall on every
    // period-th sweep cycle when period != 0. Returns the cycle of the done pulse.
    task automatic push_sweep(input bit unit, input int start, input logic [1:0] w,
                              input int period, output int done_cyc);
        int   depth;
        int   a;
        int   x;
        bit   stalled;
        evt_t e;
        depth = unit ? DB : DA;
        a = 0;
        x = start;
        while (1'b1) begin
            e = '0;
            e.cyc = x; e.grant = w; e.addr = 16'(a); e.valid = 1'b1;
            e.last = (a == depth - 1); e.busy = 1'b1;
            if (unit) qb.push_back(e); else qa.push_back(e);
            stalled = (period != 0) && (((x - start) % period) == period - 1);
            if (!stalled) begin
                if (a == depth - 1) break;
                a++;
            end
            x++;
        end
        e = '0;
        e.cyc = x + 1; e.done = w; e.busy = 1'b1;
        if (unit) qb.push_back(e); else qa.push_back(e);
        done_cyc = x + 1;
    endtask

    function automatic bit zero_a();
        return ifa.grant == 0 && ifa.mem_addr == 0 && !ifa.mem_valid && !ifa.last && ifa.done == 0 && !ifa.busy;
    endfunction

    function automatic bit zero_b();
        return ifb.grant == 0 && ifb.mem_addr == 0 && !ifb.mem_valid && !ifb.last && ifb.done == 0 && !ifb.busy;
    endfunction

    always @(negedge clk) begin : mon_a
        evt_t g;
        g = '0;
        g.cyc = cyc; g.grant = ifa.grant; g.addr = 16'(ifa.mem_addr); g.valid = ifa.mem_valid;
        g.last = ifa.last; g.busy = ifa.busy; g.done = ifa.done;
        if (ifa.mem_valid || ifa.busy || ifa.done != 0 || ifa.grant != 0) begin
            if (qa.size() == 0) tally(1'b0, $sformatf("unexpected_a got %s", fmt(g)));
            else begin
                evt_t e;
                e = qa.pop_front();
                tally(e === g, $sformatf("sweep_a got %s expected %s", fmt(g), fmt(e)));
            end
        end else begin
            tally(ifa.mem_addr == 0 && !ifa.last, $sformatf("idle_a got %s", fmt(g)));
        end
    end

    always @(negedge clk) begin : mon_b
        evt_t g;
        g = '0;
        g.cyc = cyc; g.grant = ifb.grant; g.addr = 16'(ifb.mem_addr); g.valid = ifb.mem_valid;
        g.last = ifb.last; g.busy = ifb.busy; g.done = ifb.done;
        if (ifb.mem_valid || ifb.busy || ifb.done != 0 || ifb.grant != 0) begin
            if (qb.size() == 0) tally(1'b0, $sformatf("unexpected_b got %s", fmt(g)));
            else begin
                evt_t e;
                e = qb.pop_front();
                tally(e === g, $sformatf("sweep_b got %s expected %s", fmt(g), fmt(e)));
            end
        end else begin
            tally(ifb.mem_addr == 0 && !ifb.last, $sformatf("idle_b got %s", fmt(g)));
        end
    end

    initial begin : stim
        int c;
        int d;
        int d2;
        int d3;
        logic [1:0] g1, g2, g3;
        ifa.req = 2'b00; ifa.stall = 1'b0;
        ifb.req = 2'b00; ifb.stall = 1'b0;

        #1 resetn = 1'b0;
        #1;
        tally(zero_a() && zero_b(), "reset_outputs not all zero");
        step(3);
        resetn = 1'b1;
        step(2);

        // single one-cycle request from requester 0
        c = cyc;
        ifa.req = 2'b01;
        push_sweep(1'b0, c + 1, 2'b01, 0, d);
        step(1);
        ifa.req = 2'b00;
        wait_until(d + 3);

        // requester 1 with stall on every third sweep cycle; stall in IDLE is ignored
        c = cyc;
        ifa.req = 2'b10;
        ifa.stall = 1'b1;
        push_sweep(1'b0, c + 1, 2'b10, 3, d);
        step(1);
        ifa.req = 2'b00;
        while (cyc <= d + 1) begin
            ifa.stall = (((cyc - (c + 1)) % 3) == 2);
            step(1);
        end
        ifa.stall = 1'b0;
        step(2);

        // both held across three sweeps; requester 1 owned the previous sweep
`ifdef SWEEP_ROUND_ROBIN_EN
        g1 = 2'b01; g2 = 2'b10; g3 = 2'b01;
`else
        g1 = 2'b01; g2 = 2'b01; g3 = 2'b01;
`endif
        c = cyc;
        ifa.req = 2'b11;
        push_sweep(1'b0, c + 1, g1, 0, d);
        push_sweep(1'b0, d + 2, g2, 0, d2);
        push_sweep(1'b0, d2 + 2, g3, 0, d3);
        wait_until(d2 + 3);
        ifa.req = 2'b00;
        wait_until(d3 + 3);

        // reset mid-sweep at address 1000: outputs clear at once, no done pulse
        c = cyc;
        ifa.req = 2'b01;
        push_sweep(1'b0, c + 1, 2'b01, 0, d);
        step(1);
        ifa.req = 2'b00;
        wait_until(c + 1001);
        tally(ifa.mem_addr == 16'd1000 && ifa.mem_valid,
              $sformatf("pre_reset_addr got addr=%0d valid=%b expected addr=1000 valid=1", ifa.mem_addr, ifa.mem_valid));
        #1 resetn = 1'b0;
        qa.delete();
        #1;
        tally(zero_a(), $sformatf("reset_mid got grant=%b addr=%0d valid=%b done=%b busy=%b expected all zero",
                                  ifa.grant, ifa.mem_addr, ifa.mem_valid, ifa.done, ifa.busy));
        step(2);
        resetn = 1'b1;
        step(2);
        c = cyc;
        ifa.req = 2'b11;
        push_sweep(1'b0, c + 1, 2'b01, 0, d);
        step(1);
        ifa.req = 2'b00;
        wait_until(d + 3);

        // requester 1 arrives mid-sweep, requester 0 drops: sweep completes, then requester 1
        c = cyc;
        ifa.req = 2'b01;
        push_sweep(1'b0, c + 1, 2'b01, 0, d);
        step(10);
        ifa.req = 2'b11;
        step(10);
        ifa.req = 2'b10;
        push_sweep(1'b0, d + 2, 2'b10, 0, d2);
        wait_until(d + 4);
        ifa.req = 2'b00;
        wait_until(d2 + 3);

        // DEPTH = 2^ADDR_W with held request: 0..3, DONE, IDLE, grant again at 0
        c = cyc;
        ifb.req = 2'b01;
        push_sweep(1'b1, c + 1, 2'b01, 0, d);
        push_sweep(1'b1, d + 2, 2'b01, 0, d2);
        wait_until(d + 3);
        ifb.req = 2'b00;
        wait_until(d2 + 3);

        for (int i = 0; i < 100 && (qa.size() != 0 || qb.size() != 0); i++) step(1);
        tally(qa.size() == 0 && qb.size() == 0,
              $sformatf("drain got pending_a=%0d pending_b=%0d expected 0/0", qa.size(), qb.size()));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
